pc_unit: RTL

//  Parametrised program-counter unit replacing the fixed 32-bit write-enabled PC register.

---
 rtl/pc_unit_if.sv | 34 +++
 rtl/pc_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Program-counter unit bus: control inputs from branch/trap logic and the
// fetch-address / return-address-stack view presented back to the pipeline.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            i_stall;
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            i_trap;
    logic [XLEN-1:0] i_trap_vec;
    logic            i_halt;
    logic            i_resume;
    logic            i_ras_push;
    logic            i_ras_pop;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_plus;
    logic            o_valid;
    logic            o_misalign;
    logic [XLEN-1:0] o_ras_top;
    logic            o_ras_empty;
    logic            o_ras_full;

    modport master (
        output i_stall, i_redirect_valid, i_redirect_pc, i_trap, i_trap_vec,
               i_halt, i_resume, i_ras_push, i_ras_pop,
        input  o_pc, o_pc_plus, o_valid, o_misalign, o_ras_top, o_ras_empty, o_ras_full
    );

    modport slave (
        input  i_stall, i_redirect_valid, i_redirect_pc, i_trap, i_trap_vec,
               i_halt, i_resume, i_ras_push, i_ras_pop,
        output o_pc, o_pc_plus, o_valid, o_misalign, o_ras_top, o_ras_empty, o_ras_full
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencing, trap/redirect/stall PC
// selection with alignment checking, and a circular return-address stack.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              IALIGN       = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    pc_unit_if.slave   bus
);
    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] INCR       = XLEN'(IALIGN);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_next;
    logic [XLEN-1:0]   w_pc_plus;
    logic [XLEN-1:0]   w_trap_target;
    logic              r_misalign;
    logic              w_misalign_next;
    logic              w_run;
    logic              w_redir_misaligned;
    logic              w_push;
    logic              w_pop;

    logic [XLEN-1:0]   r_ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ras_ptr;
    logic [CNT_W-1:0]  r_ras_cnt;
    logic [PTR_W-1:0]  w_ras_ptr_next;
    logic [CNT_W-1:0]  w_ras_cnt_next;
    logic              w_ras_we;
    logic [PTR_W-1:0]  w_ras_widx;

    assign w_pc_plus          = r_pc + INCR;
    assign w_trap_target      = bus.i_trap_vec & ~ALIGN_MASK;
    assign w_run              = (r_state == ST_RUN);
    assign w_redir_misaligned = ((bus.i_redirect_pc & ALIGN_MASK) != {XLEN{1'b0}});
    // A trap in the same cycle wins over any call/return bookkeeping.
    assign w_push             = w_run & bus.i_ras_push & ~bus.i_trap;
    assign w_pop              = w_run & bus.i_ras_pop  & ~bus.i_trap;

    assign bus.o_pc        = r_pc;
    assign bus.o_pc_plus   = w_pc_plus;
    assign bus.o_valid     = w_run;
    assign bus.o_misalign  = r_misalign;
    assign bus.o_ras_empty = (r_ras_cnt == CNT_ZERO);
    assign bus.o_ras_full  = (r_ras_cnt == CNT_FULL);
    assign bus.o_ras_top   = (r_ras_cnt == CNT_ZERO) ? {XLEN{1'b0}} : r_ras_mem[r_ras_ptr];

    // Run/halt sequencing: one BOOT cycle, halt blocked by a simultaneous trap.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (bus.i_halt && !bus.i_trap) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.i_resume || bus.i_trap) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HALT;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    // Next-PC selection: trap > aligned redirect > stall > sequential; a
    // misaligned redirect is dropped (PC holds) and flagged for one cycle.
    always_comb begin
        w_pc_next       = r_pc;
        w_misalign_next = 1'b0;
        if (w_run) begin
            if (bus.i_trap) begin
                w_pc_next = w_trap_target;
            end else if (bus.i_redirect_valid) begin
                if (w_redir_misaligned) begin
                    w_pc_next       = r_pc;
                    w_misalign_next = 1'b1;
                end else begin
                    w_pc_next = bus.i_redirect_pc;
                end
            end else if (bus.i_stall) begin
                w_pc_next = r_pc;
            end else begin
                w_pc_next = w_pc_plus;
            end
        end else if ((r_state == ST_HALT) && bus.i_trap) begin
            w_pc_next = w_trap_target;
        end else begin
            w_pc_next = r_pc;
        end
    end

    // RAS pointer/count update; push+pop replaces the top unless the stack is empty.
    always_comb begin
        w_ras_we       = 1'b0;
        w_ras_widx     = r_ras_ptr;
        w_ras_ptr_next = r_ras_ptr;
        w_ras_cnt_next = r_ras_cnt;
        case ({w_push, w_pop})
            2'b10: begin
                w_ras_we       = 1'b1;
                w_ras_widx     = r_ras_ptr + PTR_ONE;
                w_ras_ptr_next = r_ras_ptr + PTR_ONE;
                if (r_ras_cnt != CNT_FULL) begin
                    w_ras_cnt_next = r_ras_cnt + CNT_W'(1);
                end else begin
                    w_ras_cnt_next = r_ras_cnt;
                end
            end
            2'b01: begin
                if (r_ras_cnt != CNT_ZERO) begin
                    w_ras_ptr_next = r_ras_ptr - PTR_ONE;
                    w_ras_cnt_next = r_ras_cnt - CNT_W'(1);
                end else begin
                    w_ras_ptr_next = r_ras_ptr;
                    w_ras_cnt_next = r_ras_cnt;
                end
            end
            2'b11: begin
                w_ras_we = 1'b1;
                if (r_ras_cnt == CNT_ZERO) begin
                    w_ras_widx     = r_ras_ptr + PTR_ONE;
                    w_ras_ptr_next = r_ras_ptr + PTR_ONE;
                    w_ras_cnt_next = CNT_W'(1);
                end else begin
                    w_ras_widx     = r_ras_ptr;
                    w_ras_ptr_next = r_ras_ptr;
                    w_ras_cnt_next = r_ras_cnt;
                end
            end
            default: begin
                w_ras_we = 1'b0;
            end
        endcase
    end

    // State, PC and misalign-flag registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
        end
    end

    // RAS storage, top pointer and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ras_ptr <= {PTR_W{1'b1}};
            r_ras_cnt <= CNT_ZERO;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras_mem[i] <= {XLEN{1'b0}};
            end
        end else begin
            r_ras_ptr <= w_ras_ptr_next;
            r_ras_cnt <= w_ras_cnt_next;
            if (w_ras_we) begin
                r_ras_mem[w_ras_widx] <= w_pc_plus;
            end
        end
    end
endmodule
